// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment glyph constants and polarity helper
package seg_pkg;

    // Active-high abcdefg patterns, bit 6 = segment a
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Convert an active-high pattern to the pin polarity of the board
    function automatic logic [6:0] apply_polarity(input logic [6:0] pattern, input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - display data inputs and scanned pin outputs
interface seg_scan_driver_if #(parameter int NUM_DIGITS = 4);
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   nibbles;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic                      lz_suppress;
    logic [0:6]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     digit;
    logic                      frame_start;

    modport master (
        output enable, nibbles, dp_mask, blink_mask, blank_mask, lz_suppress,
        input  seg, dp, digit, frame_start
    );

    modport slave (
        input  enable, nibbles, dp_mask, blink_mask, blank_mask, lz_suppress,
        output seg, dp, digit, frame_start
    );
endinterface

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - nibble to active-high hex glyph
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Map each hex value to its abcdefg pattern
    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scan driver with blink, blank and zero suppression
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_CYCLES   = 100_000,
    parameter int GUARD_CYCLES   = 1_000,
    parameter int BLINK_CYCLES   = 25_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk_100MHz,
    input  logic               reset_n,
    seg_scan_driver_if.slave   bus
);

    localparam int SLOT_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]     GUARD_END  = SLOT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [6:0]            SEG_DARK   = apply_polarity(SEG_OFF, SEG_ACTIVE_LOW);
    localparam logic                  DP_DARK    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_DARK   = DIG_ACTIVE_LOW ? '1 : '0;

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;

    logic [4*NUM_DIGITS-1:0] sh_nibbles;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_blink, sh_blank;
    logic                    sh_lz;

    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   digit_q;
    logic                    frame_start_q;

    logic                    frame_latch;
    logic [4*NUM_DIGITS-1:0] src_nibbles;
    logic [NUM_DIGITS-1:0]   src_dp, src_blink, src_blank, suppressed, dig_hot;
    logic                    src_lz, zero_run, blink_off, cur_blank, dark;
    logic [3:0]              cur_nibble;
    logic [6:0]              glyph;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   digit_next;

    // Slot 0 of index 0 is the frame boundary; the first decode of a frame uses the fresh inputs
    always_comb begin
        frame_latch = bus.enable && (slot_cnt == '0) && (scan_idx == '0);
        src_nibbles = frame_latch ? bus.nibbles     : sh_nibbles;
        src_dp      = frame_latch ? bus.dp_mask     : sh_dp;
        src_blink   = frame_latch ? bus.blink_mask  : sh_blink;
        src_blank   = frame_latch ? bus.blank_mask  : sh_blank;
        src_lz      = frame_latch ? bus.lz_suppress : sh_lz;
    end

    // A digit is a leading zero when it and every digit to its left hold 0
    always_comb begin
        zero_run   = 1'b1;
        suppressed = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (src_nibbles[4*i +: 4] == 4'd0);
            suppressed[i] = src_lz & zero_run & (i != 0);
        end
    end

    seg_glyph_decode u_decode (
        .nibble (cur_nibble),
        .glyph  (glyph)
    );

    // Decode the digit under the scan pointer into pin levels
    always_comb begin
        cur_nibble = src_nibbles[4*int'(scan_idx) +: 4];
        cur_blank  = src_blank[scan_idx];
        blink_off  = src_blink[scan_idx] & blink_phase;
        dark       = cur_blank | blink_off | suppressed[scan_idx];
        seg_next   = apply_polarity(dark ? SEG_OFF : glyph, SEG_ACTIVE_LOW);
        dp_next    = (src_dp[scan_idx] & ~cur_blank & ~blink_off) ^ SEG_ACTIVE_LOW;
        dig_hot    = '0;
        if (slot_cnt >= GUARD_END) begin
            dig_hot[scan_idx] = 1'b1;
        end
        digit_next = dig_hot ^ DIG_DARK;
    end

    // Free-running blink half-period timer, unaffected by enable
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Slot counter and scan index; held at the frame start while disabled
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            scan_idx <= '0;
        end else if (!bus.enable) begin
            slot_cnt <= '0;
            scan_idx <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Shadow set captured once per frame so a frame never mixes old and new data
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sh_nibbles <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
        end else if (frame_latch) begin
            sh_nibbles <= bus.nibbles;
            sh_dp      <= bus.dp_mask;
            sh_blink   <= bus.blink_mask;
            sh_blank   <= bus.blank_mask;
            sh_lz      <= bus.lz_suppress;
        end
    end

    // Registered pin drivers; dark while disabled
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            seg_q         <= SEG_DARK;
            dp_q          <= DP_DARK;
            digit_q       <= DIG_DARK;
            frame_start_q <= 1'b0;
        end else if (!bus.enable) begin
            seg_q         <= SEG_DARK;
            dp_q          <= DP_DARK;
            digit_q       <= DIG_DARK;
            frame_start_q <= 1'b0;
        end else begin
            seg_q         <= seg_next;
            dp_q          <= dp_next;
            digit_q       <= digit_next;
            frame_start_q <= frame_latch;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.digit       = digit_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed 7-segment scan driver: N digits, hex glyphs, per-digit blink and blank masks, decimal points, leading-zero suppression and an anti-ghosting guard interval. It sits between the timekeeping/edit logic (which supplies packed nibbles plus blink/blank masks) and the board pins, replacing the fixed 4-digit BCD display driver. Display data is latched once per frame, so a scan frame never shows a mix of old and new values.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, range 1..8.
- DIGIT_CYCLES, 100_000: clocks per digit slot (1 ms at 100 MHz).
- GUARD_CYCLES, 1_000: clocks at the start of each slot with all digit enables off. Must be less than DIGIT_CYCLES.
- BLINK_CYCLES, 25_000_000: clocks per blink half-period (2 Hz blink).
- SEG_ACTIVE_LOW, 1: segment/dp polarity (1 means 0 lights the segment).
- DIG_ACTIVE_LOW, 1: digit-enable polarity.
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  display on; when low, all outputs are dark.
- nibbles  in  4*NUM_DIGITS  packed digit values; digit i is nibbles[4i+3:4i]; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  decimal point on per digit.
- blink_mask  in  NUM_DIGITS  digit blinks (glyph and dp).
- blank_mask  in  NUM_DIGITS  digit forced dark.
- lz_suppress  in  1  blank leading zeros.
- seg  out  [0:6]  segments a..g, with seg[0] = a.
- dp  out  1  decimal point.
- digit  out  NUM_DIGITS  digit enables; bit i drives digit i.
- frame_start  out  1  one-cycle pulse when slot 0 begins (frame latch point).

## Operation
- **Slot counter:** counts 0..DIGIT_CYCLES-1. On wrap, the scan index advances and wraps from NUM_DIGITS-1 to 0.
- **Frame latch:** when the scan index becomes 0 (and on the first cycle after reset or re-enable), the block latches nibbles, dp_mask, blink_mask, blank_mask and lz_suppress into a shadow set. All decode uses the shadow set only.
- **Blink timer:** counts 0..BLINK_CYCLES-1 and toggles blink_phase on wrap. It is free-running and independent of enable.
  - blink_phase = 0: glyph visible.
  - blink_phase = 1: blinking digits are dark.
- **Glyphs:** hex 0-9, A, b, C, d, E, F. Active-high patterns (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - SEG_ACTIVE_LOW inverts each pattern.
- **Leading-zero suppression:** digit i is dark if lz_suppress is set, all shadow nibbles from index NUM_DIGITS-1 down to i are 0, and i ≠ 0. Digit 0 is never suppressed. The dp on a suppressed digit is still shown if set.
- **Dark digit:** caused by blank, blink-off or suppression. seg is all off; dp follows dp_mask unless the digit is blanked or blink-off.
- **Digit enable:** only the current-index enable is active, and only for slot counter ≥ GUARD_CYCLES. During the guard interval all enables are off.
- **enable low:** seg, dp and digit go to the off level; scan index and slot counter clear to 0. When enable rises, the scan restarts at slot 0 with a fresh frame latch.

## Timing
- All outputs are registered. A shadow-set change reaches seg/dp/digit one clock later.
- Latency from a nibbles change to its display is at most one full frame (NUM_DIGITS × DIGIT_CYCLES) plus 2 clocks.
- **Reset values** (asynchronous assertion, synchronous release):
  - seg all off, dp off, digit all off, frame_start 0.
  - Slot counter 0, scan index 0, blink counter 0, blink_phase 0, shadow set 0.
- **Reset mid-scan:** outputs go dark immediately. The first frame_start comes one clock after reset_n deasserts.
- **Simultaneous events:** when a blink wrap and a slot wrap coincide, both take effect in the same cycle. The new blink_phase applies to the new slot.
- **Input changes mid-frame** are ignored until the next frame latch.
- **NUM_DIGITS = 1:** the scan index is constant 0, and frame_start pulses every slot.

## Structure
- **Shared package seg_pkg:**
  - 7-bit glyph constants GLYPH_0..GLYPH_F (active-high).
  - SEG_OFF constant.
  - Function to apply polarity.
- **Sub-module seg_glyph_decode:** combinational nibble to active-high 7-bit pattern, reused by other display blocks.
- **Top module:** slot/scan counters, blink timer, shadow registers, suppression logic and output registers.

## Test plan
Simulation parameters: NUM_DIGITS=4, DIGIT_CYCLES=8, GUARD_CYCLES=2, BLINK_CYCLES=32, active-low polarities.
- **Scan:** reset, then nibbles=16'h1234, masks 0 → digit cycles 1110, 1101, 1011, 0111. Each enable is held 6 clocks after 2 dark guard clocks. seg shows 4, 3, 2, 1 (0110011 inverted for "4").
- **Hex glyphs:** nibbles=16'hABCF → seg patterns for F, C, b, A on digits 0..3.
- **Frame coherence:** change nibbles from 16'h0000 to 16'h9999 mid-slot 2 → no 9 appears until after the next frame_start; the full frame after that shows 9999.
- **Blink:** blink_mask=4'b0011 → digits 0/1 dark for 32 clocks, then visible for 32, repeating; digits 2/3 are always lit. Blanking starts in the blink_phase=1 half-period.
- **Leading-zero suppression:** lz_suppress=1, nibbles=16'h0050 → digits 3/2 dark, digit 1 shows 5, digit 0 shows 0. With 16'h0000, only digit 0 is lit.
- **Reset and enable:** assert reset_n low mid-slot 3 → all outputs off in the same cycle; after release, frame_start pulses and the scan restarts at digit 0. Dropping enable gives the same dark behaviour, and the scan restarts at digit 0.
